mem_loader: RTL and testbench
=============================

# mem_loader

Debug-panel loader that writes user-entered 16-bit words into data memory or the general-register file. It is the write-side companion of the display path, which reads the same targets by address for the panel. Hex nibbles come from the front-panel switches on `enter` pulses and are assembled into a word. On `commit` the word is written through a request/acknowledge handshake, and the address auto-increments up to the target's size limit.

## Interface
- `GR_SIZE`, 8, number of general registers (write limit when target is GR).
- `MEM_LIMIT`, `` `MEM_SIZE `` (from define.v), write limit when target is memory; at most 256.
- `clock` in 1, sole clock, rising edge.
- `reset_n` in 1, asynchronous, active-low reset.
- `select` in 1, target: `` `GR `` means the register file, otherwise memory.
- `nibble` in 4, hex digit from the switches.
- `enter` in 1, single-cycle debounced pulse that shifts `nibble` into the word.
- `commit` in 1, single-cycle pulse that requests a write of the assembled word.
- `clear` in 1, single-cycle pulse that returns the block to its post-reset state.
- `wrAck` in 1, target acknowledge for the current write.
- `rdData` in 16, combinational read-back of the target at `address`; used only with the verify feature.
- `address` out 8, current write address.
- `wrData` out 16, assembled word; the value written.
- `memWrite` out 1, write request to memory.
- `grWrite` out 1, write request to the register file.
- `nibbleCount` out 3, number of nibbles entered, 0..4.
- `busy` out 1, high while a write or verify is in progress.
- `full` out 1, sticky; high after the write at limit-1 completes.
- `error` out 1, sticky; verify mismatch.

## Operation
- FSM states:
  - IDLE: no nibbles.
  - COLLECT: 1..4 nibbles.
  - WRITE: request asserted.
  - VERIFY: present only with the verify macro.
  - FULL.
- Input priority per cycle: `clear` > select change > `commit` > `enter`. Lower-priority pulses in the same cycle are dropped.
- `enter` in IDLE or COLLECT:
  - `wrData <= {wrData[11:0], nibble}`.
  - `nibbleCount` increments, saturating at 4; shifting continues past 4.
  - IDLE goes to COLLECT.
- `commit` with `nibbleCount`==4 in COLLECT:
  - Latch the target from `select`.
  - Go to WRITE and raise `memWrite` or `grWrite` (exactly one) and `busy`.
  - `commit` with fewer than 4 nibbles is ignored and changes no state.
- WRITE:
  - The request and `wrData` are held stable until `wrAck` is sampled high.
  - `enter`, `commit` and select changes are ignored during WRITE.
  - `wrAck` outside WRITE is ignored.
- Write completion, on ack (or at the end of VERIFY):
  - The request drops.
  - `nibbleCount` <= 0 and `wrData` <= 0.
  - If `address` == limit-1: `address` holds, `full` <= 1, go to FULL.
  - Otherwise: `address` <= `address`+1, go to IDLE.
- FULL: `enter` and `commit` are ignored; only `clear`, a select change or reset exits.
- Select change, detected against a registered copy of `select`, outside WRITE/VERIFY:
  - `address` <= 0, `nibbleCount` <= 0, `wrData` <= 0, `full` <= 0.
  - Go to IDLE.
- `clear`:
  - Same effect as a select change, and also `error` <= 0.
  - `clear` during WRITE aborts: the request drops on the next edge.
- Limits: `GR_SIZE` when the target is GR, `MEM_LIMIT` when it is memory. `address` never leaves the range 0..limit-1.

## Timing
- Reset values: `address` 0, `wrData` 0, `memWrite` 0, `grWrite` 0, `nibbleCount` 0, `busy` 0, `full` 0, `error` 0. The FSM resets to IDLE.
- Reset mid-write drops the request immediately (asynchronous).
- All outputs are registered.
- `enter` at edge N: `wrData` and `nibbleCount` update after edge N.
- `commit` at edge N: request and `busy` are high after edge N.
- `wrAck` sampled high at edge M: the request drops and `address` updates after edge M (no verify).
- Minimum commit-to-next-commit spacing is 2 cycles plus the ack wait and the 4 enters.
- A select change registers one cycle later; the reset of `address` is visible 1 cycle after the change.

## Configuration
- `LOADER_VERIFY_EN` defined:
  - On ack, enter VERIFY for one cycle; the request is low and `busy` stays high.
  - Compare `rdData` with `wrData` at the old `address`. On mismatch, `error` <= 1.
  - Completion happens at the end of VERIFY, so ack-to-address-update is 2 cycles.
- `LOADER_VERIFY_EN` undefined:
  - No VERIFY state; `rdData` is ignored.
  - `error` is constant 0 and ack-to-address-update is 1 cycle.

## Test plan
- Reset, select=MEM, enter 1,2,3,4, commit, ack after 3 cycles -> `memWrite` high for exactly those cycles with `wrData`=0x1234 at `address` 0. Afterwards `address`=1, `nibbleCount`=0, `busy`=0.
- Enter 3 nibbles then commit -> no request, `nibbleCount`=3. Enter 5 nibbles A,B,C,D,E then commit -> writes 0xBCDE.
- select=GR, write 8 words -> `grWrite` only. After the 8th ack: `address`=7, `full`=1. A further commit is ignored. Toggling select -> `address`=0, `full`=0.
- `enter` and `commit` in the same cycle with 4 nibbles -> commit wins and the nibble is dropped. `clear` during WRITE -> request drops next edge, all outputs back to reset values.
- `reset_n` low while WRITE pending -> `memWrite`/`grWrite` fall without a clock edge. A spurious `wrAck` in IDLE -> no change.
- With `LOADER_VERIFY_EN`: `rdData`=0x0000 while writing 0xBEEF -> `error`=1 two cycles after ack and `address` increments. Without the macro -> `error` stays 0.

Source files
------------

// File: rtl/mem_loader.sv
// Debug-panel loader: assembles hex nibbles into a 16-bit word and writes it to memory or the GR file.
// Optional read-back verify of each write is enabled by defining LOADER_VERIFY_EN.
`ifndef GR
`define GR 1'b1
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 256
`endif

module mem_loader #(
  parameter int GR_SIZE   = 8,
  parameter int MEM_LIMIT = `MEM_SIZE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  nibble,
  input  logic        enter,
  input  logic        commit,
  input  logic        clear,
  input  logic        wrAck,
  input  logic [15:0] rdData,
  output logic [7:0]  address,
  output logic [15:0] wrData,
  output logic        memWrite,
  output logic        grWrite,
  output logic [2:0]  nibbleCount,
  output logic        busy,
  output logic        full,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_VERIFY_EN
    S_VERIFY  = 3'd3,
`endif
    S_FULL    = 3'd4
  } state_t;

  state_t state_r;
  logic   sel_r;
  logic   target_r;
  logic   sel_change_s;
  logic   in_write_s;
  logic   at_last_s;

  function automatic logic [7:0] last_addr(input logic is_gr);
    logic [8:0] lim;
    lim = is_gr ? 9'(GR_SIZE) : 9'(MEM_LIMIT);
    return 8'(lim - 9'd1);
  endfunction

  assign sel_change_s = (select != sel_r);
  assign at_last_s    = (address == last_addr(target_r));
`ifdef LOADER_VERIFY_EN
  assign in_write_s   = (state_r == S_WRITE) || (state_r == S_VERIFY);
`else
  assign in_write_s   = (state_r == S_WRITE);
  logic rd_data_unused_s;
  assign rd_data_unused_s = ^rdData;
`endif

  // Loader FSM: nibble assembly, write handshake, address stepping and sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      sel_r       <= 1'b0;
      target_r    <= 1'b0;
      address     <= 8'd0;
      wrData      <= 16'd0;
      memWrite    <= 1'b0;
      grWrite     <= 1'b0;
      nibbleCount <= 3'd0;
      busy        <= 1'b0;
      full        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // A select change during a write is held off and applied once the write ends.
      if (!in_write_s) begin
        sel_r <= select;
      end else begin
        sel_r <= sel_r;
      end

      if (clear || (sel_change_s && !in_write_s)) begin
        state_r     <= S_IDLE;
        address     <= 8'd0;
        wrData      <= 16'd0;
        memWrite    <= 1'b0;
        grWrite     <= 1'b0;
        nibbleCount <= 3'd0;
        busy        <= 1'b0;
        full        <= 1'b0;
        if (clear) begin
          error <= 1'b0;
        end else begin
          error <= error;
        end
      end else begin
        case (state_r)
          S_IDLE, S_COLLECT: begin
            if (commit) begin
              if ((state_r == S_COLLECT) && (nibbleCount == 3'd4)) begin
                target_r <= (select == `GR);
                memWrite <= (select != `GR);
                grWrite  <= (select == `GR);
                busy     <= 1'b1;
                state_r  <= S_WRITE;
              end else begin
                state_r  <= state_r;
              end
            end else if (enter) begin
              wrData      <= {wrData[11:0], nibble};
              nibbleCount <= (nibbleCount == 3'd4) ? 3'd4 : (nibbleCount + 3'd1);
              state_r     <= S_COLLECT;
            end else begin
              state_r     <= state_r;
            end
          end

`ifdef LOADER_VERIFY_EN
          S_WRITE: begin
            if (wrAck) begin
              memWrite <= 1'b0;
              grWrite  <= 1'b0;
              state_r  <= S_VERIFY;
            end else begin
              state_r  <= S_WRITE;
            end
          end

          // rdData still reflects the old address here, so it must read back the word just written.
          S_VERIFY: begin
            if (rdData != wrData) begin
              error <= 1'b1;
            end else begin
              error <= error;
            end
            busy        <= 1'b0;
            nibbleCount <= 3'd0;
            wrData      <= 16'd0;
            if (at_last_s) begin
              full    <= 1'b1;
              state_r <= S_FULL;
            end else begin
              address <= address + 8'd1;
              state_r <= S_IDLE;
            end
          end
`else
          S_WRITE: begin
            if (wrAck) begin
              memWrite    <= 1'b0;
              grWrite     <= 1'b0;
              busy        <= 1'b0;
              nibbleCount <= 3'd0;
              wrData      <= 16'd0;
              if (at_last_s) begin
                full    <= 1'b1;
                state_r <= S_FULL;
              end else begin
                address <= address + 8'd1;
                state_r <= S_IDLE;
              end
            end else begin
              state_r <= S_WRITE;
            end
          end
`endif

          S_FULL: begin
            state_r <= S_FULL;
          end

          default: begin
            state_r  <= S_IDLE;
            memWrite <= 1'b0;
            grWrite  <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Table-driven bench for mem_loader plus directed sequences for GR fill, verify and async reset.
module tb_mem_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        select;
  logic [3:0]  nibble;
  logic        enter;
  logic        commit;
  logic        clear;
  logic        wrAck;
  logic [15:0] rdData;
  logic [7:0]  address;
  logic [15:0] wrData;
  logic        memWrite;
  logic        grWrite;
  logic [2:0]  nibbleCount;
  logic        busy;
  logic        full;
  logic        error;

  int total = 0;
  int bad   = 0;

  mem_loader dut (
    .clock(clock), .reset_n(reset_n), .select(select), .nibble(nibble),
    .enter(enter), .commit(commit), .clear(clear), .wrAck(wrAck), .rdData(rdData),
    .address(address), .wrData(wrData), .memWrite(memWrite), .grWrite(grWrite),
    .nibbleCount(nibbleCount), .busy(busy), .full(full), .error(error)
  );

  always #5 clock = ~clock;

  // Target models: written on acknowledged requests, read combinationally at address.
  logic [15:0] mem_m [0:255];
  logic [15:0] gr_m  [0:7];
  logic        force_bad;
  always @(posedge clock) begin
    if (wrAck && memWrite) mem_m[address] <= wrData;
    if (wrAck && grWrite)  gr_m[address[2:0]] <= wrData;
  end
  assign rdData = force_bad ? 16'h0000 : (select ? gr_m[address[2:0]] : mem_m[address]);

  typedef struct {
    string       nm;
    logic        s;
    logic [3:0]  n;
    logic        e, c, cl, a;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        mw, gw;
    logic [2:0]  nc;
    logic        bsy, ful;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input string nm, input logic s, input logic [3:0] n,
                     input logic e, input logic c, input logic cl, input logic a,
                     input logic [7:0] addr, input logic [15:0] wd, input logic mw,
                     input logic gw, input logic [2:0] nc, input logic bsy, input logic ful);
    vec_t v;
    v.nm = nm; v.s = s; v.n = n; v.e = e; v.c = c; v.cl = cl; v.a = a;
    v.addr = addr; v.wd = wd; v.mw = mw; v.gw = gw; v.nc = nc; v.bsy = bsy; v.ful = ful;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic [3:0] n, input logic e,
                     input logic c, input logic cl, input logic a);
    select = s; nibble = n; enter = e; commit = c; clear = cl; wrAck = a;
    @(posedge clock);
    #1;
    enter = 1'b0; commit = 1'b0; clear = 1'b0; wrAck = 1'b0;
  endtask

  task automatic ack_cycle(input logic s);
    cyc(s, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef LOADER_VERIFY_EN
    cyc(s, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic load4(input logic s, input logic [15:0] w);
    cyc(s, w[15:12], 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(s, w[11:8],  1'b1, 1'b0, 1'b0, 1'b0);
    cyc(s, w[7:4],   1'b1, 1'b0, 1'b0, 1'b0);
    cyc(s, w[3:0],   1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic        prev_busy;
    logic [15:0] word;
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    for (int i = 0; i < 8; i++) gr_m[i] = 16'h0000;
    force_bad = 1'b0;
    reset_n = 1'b0; select = 1'b0; nibble = 4'h0;
    enter = 1'b0; commit = 1'b0; clear = 1'b0; wrAck = 1'b0;

    //    name        s     n     e     c     cl    a     addr   wd        mw    gw    nc    bsy   ful
    add("idle",     1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("e1",       1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("e2",       1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0012, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add("e3",       1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0123, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add("e4",       1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h1234, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add("commit1",  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'h1234, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("hold1",    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h1234, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("hold2",    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h1234, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("ack1",     1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("eA",       1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'h000A, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("eB",       1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'h00AB, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add("eC",       1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0ABC, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add("commit3n", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'h0ABC, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add("eD",       1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'hABCD, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add("eE_sat",   1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'hBCDE, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add("commit5n", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hBCDE, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("ack2",     1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("spur_ack", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("e5",       1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0005, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("e6",       1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0056, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add("e7",       1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0567, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add("e8",       1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add("commit_e", 1'b0, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("e_in_wr",  1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("c_in_wr",  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("sel_in_wr",1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("sel_back", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 16'h5678, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("ack3",     1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("f1",       1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'h0001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("f2",       1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'h0011, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add("f3",       1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'h0111, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add("f4",       1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'h1111, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add("commit6",  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 16'h1111, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    add("clr_wr",   1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("e7b",      1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0007, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("clr_e",    1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("e9",       1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0009, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add("sel_e",    1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add("sel_mem",  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset values while reset_n is still asserted.
    #1;
    chk("rst_addr", {8'h00, address}, 16'h0000);
    chk("rst_wd", wrData, 16'h0000);
    chk("rst_req", {14'h0000, memWrite, grWrite}, 16'h0000);
    chk("rst_nc", {13'h0000, nibbleCount}, 16'h0000);
    chk("rst_flags", {13'h0000, busy, full, error}, 16'h0000);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    prev_busy = 1'b0;
    foreach (vecs[i]) begin
      cyc(vecs[i].s, vecs[i].n, vecs[i].e, vecs[i].c, vecs[i].cl, vecs[i].a);
`ifdef LOADER_VERIFY_EN
      if (vecs[i].a && prev_busy) cyc(vecs[i].s, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      prev_busy = vecs[i].bsy;
      chk({vecs[i].nm, "_addr"}, {8'h00, address}, {8'h00, vecs[i].addr});
      chk({vecs[i].nm, "_wd"}, wrData, vecs[i].wd);
      chk({vecs[i].nm, "_mw"}, {15'h0000, memWrite}, {15'h0000, vecs[i].mw});
      chk({vecs[i].nm, "_gw"}, {15'h0000, grWrite}, {15'h0000, vecs[i].gw});
      chk({vecs[i].nm, "_nc"}, {13'h0000, nibbleCount}, {13'h0000, vecs[i].nc});
      chk({vecs[i].nm, "_busy"}, {15'h0000, busy}, {15'h0000, vecs[i].bsy});
      chk({vecs[i].nm, "_full"}, {15'h0000, full}, {15'h0000, vecs[i].ful});
      chk({vecs[i].nm, "_err"}, {15'h0000, error}, 16'h0000);
    end
    chk("mem0", mem_m[0], 16'h1234);
    chk("mem1", mem_m[1], 16'hBCDE);
    chk("mem2", mem_m[2], 16'h5678);

    // Fill all eight general registers and hit the limit.
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gr_sel_addr", {8'h00, address}, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      word = 16'hC000 | 16'(k);
      load4(1'b1, word);
      cyc(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("gr_req", {14'h0000, memWrite, grWrite}, 16'h0001);
      ack_cycle(1'b1);
      chk("gr_addr", {8'h00, address}, (k == 7) ? 16'd7 : 16'(k + 1));
      chk("gr_full", {15'h0000, full}, (k == 7) ? 16'd1 : 16'd0);
      chk("gr_busy", {15'h0000, busy}, 16'h0000);
      chk("gr_data", gr_m[k], word);
    end
    cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_enter", {13'h0000, nibbleCount}, 16'h0000);
    cyc(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_commit", {14'h0000, grWrite, busy}, 16'h0000);
    chk("full_hold", {7'h00, full, address}, 16'h0107);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("toggle_clr", {7'h00, full, address}, 16'h0000);

    // Read-back mismatch on a 0xBEEF write.
    load4(1'b0, 16'hBEEF);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    force_bad = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef LOADER_VERIFY_EN
    chk("vfy_phase", {8'h00, error, busy, memWrite, address[4:0]}, 16'h0040);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("vfy_err", {14'h0000, error, busy}, 16'h0002);
    chk("vfy_addr", {8'h00, address}, 16'h0001);
    force_bad = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("vfy_clr", {15'h0000, error}, 16'h0000);
`else
    chk("nv_addr", {8'h00, address}, 16'h0001);
    chk("nv_err", {15'h0000, error}, 16'h0000);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nv_err2", {15'h0000, error}, 16'h0000);
    force_bad = 1'b0;
`endif

    // Asynchronous reset in the middle of a pending write.
    load4(1'b0, 16'h4321);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ar_req_on", {15'h0000, memWrite}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req_off", {13'h0000, memWrite, grWrite, busy}, 16'h0000);
    chk("ar_state", {address, 5'h00, nibbleCount}, 16'h0000);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
